pwm_led_array: RTL and testbench
================================

// Module: pwm_led_array
// PURPOSE
//  Parametrised N-channel PWM LED driver; successor to the fixed 3x8-bit RGB driver.
//  Per-channel duty written into shadow registers over a simple write port.
//  Shadow registers are committed atomically at a PWM period boundary, giving glitch-free colour changes.
//  Sits between the control/colour logic and the board LED pins; all outputs are registered.
// PARAMETERS
//  N_CHANNELS  3    number of PWM outputs (1..32)
//  WIDTH       8    duty resolution in bits (2..16); period = 2**WIDTH-1 ticks
//  PRESCALE    1    clock cycles per PWM tick (>=1); 1 = tick every clock
//  FADE_STEP   1    duty increment per period when PWM_FADE_EN is defined (1..2**WIDTH-1)
// PORTS
//  clock_100mhz  in   1                      system clock
//  reset_n       in   1                      asynchronous active-low reset
//  wr_en         in   1                      write wr_duty into shadow[wr_channel]
//  wr_channel    in   $clog2(N_CHANNELS)||1  target channel index
//  wr_duty       in   WIDTH                  duty value, 0 = off, 2**WIDTH-1 = fully on
//  commit        in   1                      request shadow->active transfer at next period boundary
//  commit_pending out 1                      commit requested, not yet applied
//  period_start  out  1                      one-cycle pulse on first clock of each PWM period
//  led_out       out  N_CHANNELS             PWM outputs, active high
// BEHAVIOUR
//  Reset (async, reset_n=0): prescaler=0, counter=0, shadow=0, active=0, led_out=0,
//   commit_pending=0, period_start=0. Deassertion is synchronised externally.
//  Prescaler: counts 0..PRESCALE-1; tick asserted on the cycle it equals PRESCALE-1.
//   PRESCALE=1 -> tick every cycle.
//  Counter: advances on tick, 0..2**WIDTH-2, then wraps to 0.
//   wrap = tick && counter==2**WIDTH-2.
//  Output: led_out[i] <= (active[i] > counter), registered, 1-cycle latency from counter.
//   Duty 0: never high. Duty 2**WIDTH-1: constantly high. Duty d: high d ticks per period.
//  period_start: registered, pulses the cycle after wrap, i.e. aligned with counter==0.
//  Write port: wr_en updates shadow[wr_channel] next cycle.
//   wr_channel >= N_CHANNELS is ignored (no state change).
//   Writes never affect active directly.
//  Commit: commit=1 sets commit_pending next cycle.
//   On a wrap cycle with commit_pending=1: active <= shadow (including a same-cycle write),
//   commit_pending <= 0 unless commit is also high that cycle (then stays 1 for next period).
//   Commit on a wrap cycle with commit_pending=0 is applied at the following wrap.
//   Repeated commit while pending: no extra effect.
//  Reset mid-period: all state cleared immediately; outputs low within reset assertion, no partial pulse.
// CONFIGURATION
//  PWM_FADE_EN undefined: commit loads active directly from shadow as above.
//  PWM_FADE_EN defined: commit loads a per-channel target register instead.
//   At every wrap, each active moves toward target by FADE_STEP, saturating exactly at target
//   (no overshoot; unsigned, width WIDTH+1 intermediate).
//   commit_pending clears when the commit is captured, not at fade completion.
//   Extra output fade_busy (1 bit): high while any active != target; reset 0.
// TESTING
//  Use N_CHANNELS=3, WIDTH=8, PRESCALE=1 unless stated.
//  Reset: reset_n=0 mid-period with active=0x80 -> led_out=0 immediately, all outputs 0, counter restarts at 0.
//  Duty sweep: write 0x00/0x40/0xFF to ch0/1/2, commit -> after next wrap, per 255-cycle period:
//   ch0 high 0, ch1 high 64, ch2 high 255 cycles.
//  Atomicity: commit 0x40, then mid-period write 0x80 to ch1 without commit -> ch1 remains 64 cycles high indefinitely.
//   Then commit -> 128 cycles high from next period.
//  Boundary: commit asserted on wrap cycle with pending=0 -> applied one full period later.
//   wr_en+commit on wrap with pending=1 -> same-cycle write included.
//  Prescale/invalid index: PRESCALE=4, duty 0x10 -> 64 cycles high per 1020-cycle period.
//   Write to wr_channel=3 -> no change.
//  Fade (PWM_FADE_EN, FADE_STEP=16): 0x00 -> 0x50 committed -> duty 16,32,48,64,80 on successive periods.
//   fade_busy drops on the period reaching 80.

Source files
------------

// File: rtl/pwm_led_array.sv
// N-channel PWM LED driver with shadow duty registers committed atomically at the period boundary.
// Optional PWM_FADE_EN: commit loads a target and each active duty ramps toward it by FADE_STEP per period.
module pwm_led_array #(
  parameter int N_CHANNELS = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 1,
  parameter int FADE_STEP  = 1,
  localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clock_100mhz,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_channel,
  input  logic [WIDTH-1:0]      wr_duty,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic                  period_start,
  output logic [N_CHANNELS-1:0] led_out
`ifdef PWM_FADE_EN
  ,
  output logic                  fade_busy
`endif
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'((1 << WIDTH) - 2);

  logic             tick;
  logic             wrap;
  logic             apply;
  logic             wr_hit;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] shadow     [N_CHANNELS];
  logic [WIDTH-1:0] shadow_nxt [N_CHANNELS];
  logic [WIDTH-1:0] active     [N_CHANNELS];
  logic [WIDTH-1:0] active_nxt [N_CHANNELS];

  generate
    if (PRESCALE > 1) begin : g_prescale
      logic [PS_W-1:0] ps_cnt;
      always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n)                          ps_cnt <= '0;
        else if (ps_cnt == PS_W'(PRESCALE-1))  ps_cnt <= '0;
        else                                   ps_cnt <= ps_cnt + 1'b1;
      end
      assign tick = (ps_cnt == PS_W'(PRESCALE-1));
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  assign wrap   = tick && (counter == CNT_MAX);
  assign apply  = wrap && commit_pending;
  assign wr_hit = wr_en && (32'(wr_channel) < N_CHANNELS);

  // A write landing on the applying wrap cycle is part of the committed set.
  always_comb begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      shadow_nxt[i] = shadow[i];
      if (wr_hit && (wr_channel == CH_W'(i))) shadow_nxt[i] = wr_duty;
    end
  end

`ifdef PWM_FADE_EN
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(FADE_STEP);

  logic [WIDTH-1:0] target     [N_CHANNELS];
  logic [WIDTH-1:0] target_nxt [N_CHANNELS];
  logic             busy_nxt;

  function automatic logic [WIDTH-1:0] fade_to(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0]   up;
    logic [WIDTH:0]   gap;
    logic [WIDTH-1:0] res;
    up  = {1'b0, cur} + STEP;
    gap = {1'b0, cur} - {1'b0, tgt};
    res = tgt;
    if (cur < tgt) begin
      if (up < {1'b0, tgt}) res = up[WIDTH-1:0];
    end else if (cur > tgt) begin
      if (gap > STEP) res = cur - STEP[WIDTH-1:0];
    end
    return res;
  endfunction

  always_comb begin
    busy_nxt = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      target_nxt[i] = apply ? shadow_nxt[i] : target[i];
      active_nxt[i] = wrap ? fade_to(active[i], target_nxt[i]) : active[i];
      if (active_nxt[i] != target_nxt[i]) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      fade_busy <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) target[i] <= '0;
    end else begin
      fade_busy <= busy_nxt;
      for (int i = 0; i < N_CHANNELS; i++) target[i] <= target_nxt[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      active_nxt[i] = apply ? shadow_nxt[i] : active[i];
    end
  end
`endif

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      counter        <= '0;
      commit_pending <= 1'b0;
      period_start   <= 1'b0;
      led_out        <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (tick) counter <= wrap ? '0 : counter + 1'b1;
      // A commit on the applying wrap re-arms for the following period.
      if (apply)       commit_pending <= commit;
      else if (commit) commit_pending <= 1'b1;
      period_start <= wrap;
      for (int i = 0; i < N_CHANNELS; i++) begin
        shadow[i]  <= shadow_nxt[i];
        active[i]  <= active_nxt[i];
        led_out[i] <= (active[i] > counter);
      end
    end
  end

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed bench for pwm_led_array: reset, duty sweep, commit atomicity, wrap-cycle boundaries,
// prescaler and invalid channel index; fade ramp when built with PWM_FADE_EN.
module tb_pwm_led_array;

  logic       clock_100mhz = 1'b0;
  logic       reset_n      = 1'b1;
  logic       wr_en        = 1'b0;
  logic [1:0] wr_channel   = '0;
  logic [7:0] wr_duty      = '0;
  logic       commit       = 1'b0;

  logic       commit_pending, period_start;
  logic [2:0] led_out;
  logic       pend_ps, pstart_ps;
  logic [2:0] led_ps;
`ifdef PWM_FADE_EN
  logic       fade_busy, fade_busy_ps;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock_100mhz = ~clock_100mhz;

  pwm_led_array #(.N_CHANNELS(3), .WIDTH(8), .PRESCALE(1), .FADE_STEP(16)) dut (
    .clock_100mhz(clock_100mhz), .reset_n(reset_n), .wr_en(wr_en),
    .wr_channel(wr_channel), .wr_duty(wr_duty), .commit(commit),
    .commit_pending(commit_pending), .period_start(period_start), .led_out(led_out)
`ifdef PWM_FADE_EN
    , .fade_busy(fade_busy)
`endif
  );

  pwm_led_array #(.N_CHANNELS(3), .WIDTH(8), .PRESCALE(4), .FADE_STEP(16)) dut_ps (
    .clock_100mhz(clock_100mhz), .reset_n(reset_n), .wr_en(wr_en),
    .wr_channel(wr_channel), .wr_duty(wr_duty), .commit(commit),
    .commit_pending(pend_ps), .period_start(pstart_ps), .led_out(led_ps)
`ifdef PWM_FADE_EN
    , .fade_busy(fade_busy_ps)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock_100mhz);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic do_write(input int ch, input int duty);
    wr_en = 1'b1; wr_channel = 2'(ch); wr_duty = 8'(duty);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_applied(input bit use_ps);
    int n = 0;
    while ((use_ps ? pend_ps : commit_pending) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if ((use_ps ? pend_ps : commit_pending) !== 1'b0) begin
      errors++;
      $display("FAIL wait_applied: commit_pending still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 4000);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_ps: no period_start within %0d cycles", n);
    end
  endtask

  task automatic count_high(input bit use_ps, input int ch, input int ncyc, output int hi);
    hi = 0;
    repeat (ncyc) begin
      step();
      if (use_ps ? led_ps[ch] : led_out[ch]) hi++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int hi;
    int n;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({led_out, period_start, commit_pending} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000", {led_out, period_start, commit_pending});
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) do_write(c, 8'h80);
    do_commit();
    checks++;
    if (commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_sets_pending: got %b required 1", commit_pending);
    end
    wait_applied(1'b0);
    repeat (50) step();
    checks++;
    if (led_out !== 3'b111) begin
      errors++;
      $display("FAIL mid_period_led: got %b required 111", led_out);
    end
    do_commit();
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_led_immediate: got %b required 000", led_out);
    end
    checks++;
    if ({period_start, commit_pending} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags_immediate: got %b required 00", {period_start, commit_pending});
    end
    step();
    step();
    reset_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 1000);
    checks++;
    if (n !== 255) begin
      errors++;
      $display("FAIL counter_restart: first period_start after %0d cycles, required 255", n);
    end
    do_commit();
    wait_applied(1'b0);
    for (int c = 0; c < 3; c++) begin
      count_high(1'b0, c, 255, hi);
      checks++;
      if (hi !== 0) begin
        errors++;
        $display("FAIL shadow_cleared ch%0d: high %0d required 0", c, hi);
      end
    end
  endtask

  task automatic test_duty_sweep();
    int hi;
    int exp_hi [3] = '{0, 64, 255};
    do_write(0, 8'h00);
    do_write(1, 8'h40);
    do_write(2, 8'hFF);
    do_commit();
    wait_applied(1'b0);
    for (int c = 0; c < 3; c++) begin
      count_high(1'b0, c, 255, hi);
      checks++;
      if (hi !== exp_hi[c]) begin
        errors++;
        $display("FAIL duty_sweep ch%0d: high %0d required %0d", c, hi, exp_hi[c]);
      end
    end
  endtask

  task automatic test_atomicity();
    int hi;
    do_write(1, 8'h40);
    do_commit();
    wait_applied(1'b0);
    repeat (100) step();
    do_write(1, 8'h80);
    wait_ps();
    for (int p = 0; p < 2; p++) begin
      count_high(1'b0, 1, 255, hi);
      checks++;
      if (hi !== 64) begin
        errors++;
        $display("FAIL uncommitted_write period%0d: high %0d required 64", p, hi);
      end
    end
    do_commit();
    wait_applied(1'b0);
    count_high(1'b0, 1, 255, hi);
    checks++;
    if (hi !== 128) begin
      errors++;
      $display("FAIL committed_write: high %0d required 128", hi);
    end
  endtask

  task automatic test_boundary();
    int hi;
    // commit landing on a wrap with nothing pending waits a full period
    do_write(0, 8'h20);
    wait_ps();
    repeat (254) step();
    do_commit();
    checks++;
    if ({period_start, commit_pending} !== 2'b11) begin
      errors++;
      $display("FAIL wrap_commit_flags: got %b required 11", {period_start, commit_pending});
    end
    count_high(1'b0, 0, 255, hi);
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL wrap_commit_deferred: high %0d required 0", hi);
    end
    checks++;
    if (commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL wrap_commit_cleared: got %b required 0", commit_pending);
    end
    count_high(1'b0, 0, 255, hi);
    checks++;
    if (hi !== 32) begin
      errors++;
      $display("FAIL wrap_commit_applied: high %0d required 32", hi);
    end
    // write + commit on the applying wrap: write included, pending stays set
    do_commit();
    repeat (253) step();
    wr_en = 1'b1; wr_channel = 2'd2; wr_duty = 8'h10; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    checks++;
    if (commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL recommit_pending: got %b required 1", commit_pending);
    end
    count_high(1'b0, 2, 255, hi);
    checks++;
    if (hi !== 16) begin
      errors++;
      $display("FAIL same_cycle_write: high %0d required 16", hi);
    end
    checks++;
    if (commit_pending !== 1'b0) begin
      errors++;
      $display("FAIL recommit_cleared: got %b required 0", commit_pending);
    end
  endtask

  task automatic test_prescale_invalid();
    int hi;
    int exp_hi [3] = '{16, 0, 0};
    apply_reset();
    do_write(0, 8'h10);
    do_commit();
    wait_applied(1'b1);
    count_high(1'b1, 0, 1020, hi);
    checks++;
    if (hi !== 64) begin
      errors++;
      $display("FAIL prescale_duty: high %0d required 64", hi);
    end
    do_write(3, 8'hFF);
    do_commit();
    wait_applied(1'b0);
    for (int c = 0; c < 3; c++) begin
      count_high(1'b0, c, 255, hi);
      checks++;
      if (hi !== exp_hi[c]) begin
        errors++;
        $display("FAIL invalid_index ch%0d: high %0d required %0d", c, hi, exp_hi[c]);
      end
    end
  endtask

`ifdef PWM_FADE_EN
  task automatic test_fade();
    int hi;
    apply_reset();
    do_write(0, 8'h50);
    do_commit();
    wait_applied(1'b0);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (fade_busy !== (k < 5)) begin
        errors++;
        $display("FAIL fade_busy step%0d: got %b required %b", k, fade_busy, (k < 5));
      end
      count_high(1'b0, 0, 255, hi);
      checks++;
      if (hi !== 16 * k) begin
        errors++;
        $display("FAIL fade_duty step%0d: high %0d required %0d", k, hi, 16 * k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PWM_FADE_EN
    test_fade();
`else
    test_duty_sweep();
    test_atomicity();
    test_boundary();
    test_prescale_invalid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
